// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int fifo_clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fifo_gen_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Define FIFO_HARD_MEM to map onto the dual_port_ram macro instead.
module fifo_gen_dpram
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 60,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

`ifdef FIFO_HARD_MEM
  dual_port_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`else
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  // Write port and registered read port; read data holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/fifo_sync_gen.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// sticky error flags and an optional first-word-fall-through read mode.
module fifo_sync_gen
  import fifo_pkg::*;
#(
  parameter int DW       = 60,
  parameter int AW       = 8,
  parameter int AF_LEVEL = (1 << AW) - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = FIFO_STD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH   = 1 << AW;
  localparam int          CW      = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = CW'(AE_LEVEL);
  localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH || DW < 1 ||
      (FWFT != FIFO_STD && FWFT != FIFO_FWFT) || fifo_clog2(DEPTH + 1) != CW) begin : g_bad_params
    $error("fifo_sync_gen: illegal parameter combination");
  end

  logic [AW-1:0] wp, rp;
  logic [DW-1:0] ram_rdata, head;
  logic          head_valid, mid_valid, rd_seen;
  logic          wr_acc, pop, rd_issue, head_load, mid_next;
  logic [AW:0]   ram_words;

  assign full         = (count == DEPTH_C);
  assign empty        = IS_FWFT ? ~head_valid : (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Standard mode shows the RAM read register directly, forced to zero until
  // the first pop after reset; FWFT mode shows the head register.
  assign dout = IS_FWFT ? head : (rd_seen ? ram_rdata : '0);

  // Acceptance and prefetch decisions, all from registered state.
  // In FWFT mode mid_valid marks a word sitting in the RAM read register
  // that has not yet moved into the head register.
  always_comb begin
    wr_acc    = we & ~full;
    pop       = re & ~empty;
    ram_words = count - {{AW{1'b0}}, head_valid} - {{AW{1'b0}}, mid_valid};
    head_load = 1'b0;
    rd_issue  = pop;
    mid_next  = 1'b0;
    if (IS_FWFT) begin
      head_load = mid_valid & (~head_valid | pop);
      rd_issue  = (ram_words != '0) & (~mid_valid | head_load);
      mid_next  = rd_issue | (mid_valid & ~head_load);
    end
  end

  fifo_gen_dpram #(
    .DWIDTH (DW),
    .AWIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc & ~clr),
    .wr_addr (wp),
    .wr_data (din),
    .rd_en   (rd_issue),
    .rd_addr (rp),
    .rd_data (ram_rdata)
  );

  // Pointers, occupancy, sticky errors and the FWFT head/prefetch pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      rd_seen    <= 1'b0;
      mid_valid  <= 1'b0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (clr) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      rd_seen    <= 1'b0;
      mid_valid  <= 1'b0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (wr_acc)    wp <= wp + 1'b1;
      if (rd_issue)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};
      if (we & full)  overflow  <= 1'b1;
      if (re & empty) underflow <= 1'b1;
      if (pop)        rd_seen   <= 1'b1;
      mid_valid <= mid_next;
      if (head_load) begin
        head_valid <= 1'b1;
        head       <= ram_rdata;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule
